// File: rtl/operand_fetch.sv
// Register-read stage: arbitrates register-file access between write-back and operand reads,
// and hands a latched operand pair to execute. Define OPF_PERF_CNT_EN to add the decode stall counter.
module operand_fetch #(
    parameter int REG_WIDTH    = 16,
    parameter int WB_BURST_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_1_dec_valid,
    output logic                 o_1_dec_ready,
    input  logic [3:0]           i_4_dec_rn,
    input  logic [3:0]           i_4_dec_rm,
    input  logic [3:0]           i_4_dec_rd,
    input  logic [REG_WIDTH-1:0] i_R_dec_pc,
    input  logic                 i_1_wb_valid,
    output logic                 o_1_wb_ready,
    input  logic [3:0]           i_4_wb_addr,
    input  logic [REG_WIDTH-1:0] i_R_wb_data,
    output logic [3:0]           o_4_rd1_addr,
    output logic [3:0]           o_4_rd2_addr,
    output logic [3:0]           o_4_wr_addr,
    output logic [REG_WIDTH-1:0] o_R_wr_data,
    output logic                 o_1_reg_wr_en,
    output logic [REG_WIDTH-1:0] o_R_pcplus,
    input  logic [REG_WIDTH-1:0] i_R_rd1_data,
    input  logic [REG_WIDTH-1:0] i_R_rd2_data,
    output logic                 o_1_ex_valid,
    input  logic                 i_1_ex_ready,
    output logic [REG_WIDTH-1:0] or_R_op1,
    output logic [REG_WIDTH-1:0] or_R_op2,
    output logic [3:0]           or_4_ex_rd
`ifdef OPF_PERF_CNT_EN
    ,
    output logic [15:0]          o_16_stall_cnt
`endif
);

    typedef enum logic {
        S_IDLE,
        S_CAPTURE
    } state_e;

    localparam logic [3:0] BURST_MAX = 4'(WB_BURST_MAX);

    state_e               state_q, state_d;
    logic [3:0]           burst_q, burst_d;
    logic [3:0]           rn_q, rn_d;
    logic [3:0]           rm_q, rm_d;
    logic [3:0]           rd_q, rd_d;
    logic [REG_WIDTH-1:0] pc_q, pc_d;
    logic                 ex_valid_q, ex_valid_d;
    logic [REG_WIDTH-1:0] op1_q, op1_d;
    logic [REG_WIDTH-1:0] op2_q, op2_d;
    logic [3:0]           ex_rd_q, ex_rd_d;

    logic slot_free;
    logic force_issue;
    logic wr_grant;
    logic issue;

    // Grants are qualified with rst_n so no write or accept escapes while reset is held.
    always_comb begin
        slot_free   = !ex_valid_q || i_1_ex_ready;
        force_issue = i_1_dec_valid && slot_free && (burst_q == BURST_MAX);
        wr_grant    = rst_n && (state_q == S_IDLE) && i_1_wb_valid && !force_issue;
        issue       = rst_n && (state_q == S_IDLE) && !wr_grant && i_1_dec_valid && slot_free;
    end

    always_comb begin
        state_d       = state_q;
        burst_d       = burst_q;
        rn_d          = rn_q;
        rm_d          = rm_q;
        rd_d          = rd_q;
        pc_d          = pc_q;
        ex_valid_d    = ex_valid_q && !i_1_ex_ready;
        op1_d         = op1_q;
        op2_d         = op2_q;
        ex_rd_d       = ex_rd_q;
        o_1_dec_ready = 1'b0;
        o_1_wb_ready  = 1'b0;
        o_1_reg_wr_en = 1'b0;
        o_4_wr_addr   = i_4_wb_addr;
        o_R_wr_data   = i_R_wb_data;
        o_4_rd1_addr  = i_4_dec_rn;
        o_4_rd2_addr  = i_4_dec_rm;
        o_R_pcplus    = i_R_dec_pc;

        case (state_q)
            S_IDLE: begin
                if (wr_grant) begin
                    o_1_wb_ready  = 1'b1;
                    // r15 is owned by fetch: the request is consumed but never written.
                    o_1_reg_wr_en = (i_4_wb_addr != 4'hF);
                    if (i_1_dec_valid)
                        burst_d = (burst_q == BURST_MAX) ? burst_q : 4'(burst_q + 4'd1);
                    else
                        burst_d = '0;
                end else if (issue) begin
                    o_1_dec_ready = 1'b1;
                    rn_d          = i_4_dec_rn;
                    rm_d          = i_4_dec_rm;
                    rd_d          = i_4_dec_rd;
                    pc_d          = i_R_dec_pc;
                    burst_d       = '0;
                    state_d       = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                o_4_rd1_addr = rn_q;
                o_4_rd2_addr = rm_q;
                o_R_pcplus   = pc_q;
                op1_d        = i_R_rd1_data;
                op2_d        = i_R_rd2_data;
                ex_rd_d      = rd_q;
                ex_valid_d   = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            burst_q    <= '0;
            rn_q       <= '0;
            rm_q       <= '0;
            rd_q       <= '0;
            pc_q       <= '0;
            ex_valid_q <= 1'b0;
            op1_q      <= '0;
            op2_q      <= '0;
            ex_rd_q    <= '0;
        end else begin
            state_q    <= state_d;
            burst_q    <= burst_d;
            rn_q       <= rn_d;
            rm_q       <= rm_d;
            rd_q       <= rd_d;
            pc_q       <= pc_d;
            ex_valid_q <= ex_valid_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            ex_rd_q    <= ex_rd_d;
        end
    end

    assign o_1_ex_valid = ex_valid_q;
    assign or_R_op1     = op1_q;
    assign or_R_op2     = op2_q;
    assign or_4_ex_rd   = ex_rd_q;

`ifdef OPF_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (i_1_dec_valid && !o_1_dec_ready && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_q <= '0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign o_16_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch, with a behavioural 16-entry register file
// (all registers reset to 1, r15 reads return the PC+ input).
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_1_dec_valid = 1'b0;
    logic        o_1_dec_ready;
    logic [3:0]  i_4_dec_rn = '0;
    logic [3:0]  i_4_dec_rm = '0;
    logic [3:0]  i_4_dec_rd = '0;
    logic [15:0] i_R_dec_pc = '0;
    logic        i_1_wb_valid = 1'b0;
    logic        o_1_wb_ready;
    logic [3:0]  i_4_wb_addr = '0;
    logic [15:0] i_R_wb_data = '0;
    logic [3:0]  o_4_rd1_addr;
    logic [3:0]  o_4_rd2_addr;
    logic [3:0]  o_4_wr_addr;
    logic [15:0] o_R_wr_data;
    logic        o_1_reg_wr_en;
    logic [15:0] o_R_pcplus;
    logic [15:0] rf_rd1;
    logic [15:0] rf_rd2;
    logic        o_1_ex_valid;
    logic        i_1_ex_ready = 1'b0;
    logic [15:0] or_R_op1;
    logic [15:0] or_R_op2;
    logic [3:0]  or_4_ex_rd;

    int unsigned total = 0;
    int unsigned bad = 0;

    logic [15:0] mem [16];

    always #5 clk = ~clk;

    operand_fetch #(.REG_WIDTH(16), .WB_BURST_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_1_dec_valid(i_1_dec_valid), .o_1_dec_ready(o_1_dec_ready),
        .i_4_dec_rn(i_4_dec_rn), .i_4_dec_rm(i_4_dec_rm), .i_4_dec_rd(i_4_dec_rd),
        .i_R_dec_pc(i_R_dec_pc),
        .i_1_wb_valid(i_1_wb_valid), .o_1_wb_ready(o_1_wb_ready),
        .i_4_wb_addr(i_4_wb_addr), .i_R_wb_data(i_R_wb_data),
        .o_4_rd1_addr(o_4_rd1_addr), .o_4_rd2_addr(o_4_rd2_addr),
        .o_4_wr_addr(o_4_wr_addr), .o_R_wr_data(o_R_wr_data),
        .o_1_reg_wr_en(o_1_reg_wr_en), .o_R_pcplus(o_R_pcplus),
        .i_R_rd1_data(rf_rd1), .i_R_rd2_data(rf_rd2),
        .o_1_ex_valid(o_1_ex_valid), .i_1_ex_ready(i_1_ex_ready),
        .or_R_op1(or_R_op1), .or_R_op2(or_R_op2), .or_4_ex_rd(or_4_ex_rd)
    );

    // Register file: write when wr_en, otherwise sample read addresses; r15 returns PC+.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'h0001;
            rf_rd1 <= '0;
            rf_rd2 <= '0;
        end else if (o_1_reg_wr_en) begin
            if (o_4_wr_addr != 4'hF) mem[o_4_wr_addr] <= o_R_wr_data;
        end else begin
            rf_rd1 <= (o_4_rd1_addr == 4'hF) ? o_R_pcplus : mem[o_4_rd1_addr];
            rf_rd2 <= (o_4_rd2_addr == 4'hF) ? o_R_pcplus : mem[o_4_rd2_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input logic v, input logic [3:0] rn, input logic [3:0] rm,
                           input logic [3:0] rd, input logic [15:0] pc);
        i_1_dec_valid = v;
        i_4_dec_rn    = rn;
        i_4_dec_rm    = rm;
        i_4_dec_rd    = rd;
        i_R_dec_pc    = pc;
    endtask

    task automatic set_wb(input logic v, input logic [3:0] addr, input logic [15:0] data);
        i_1_wb_valid = v;
        i_4_wb_addr  = addr;
        i_R_wb_data  = data;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_wb(1'b1, 4'd4, 16'hBEEF);
        set_dec(1'b1, 4'd2, 4'd3, 4'd5, 16'h0010);
        #2;
        total++; if (o_1_ex_valid !== 1'b0) begin bad++; $display("FAIL reset_ex_valid got=%0h exp=0", o_1_ex_valid); end
        total++; if (or_R_op1 !== 16'h0) begin bad++; $display("FAIL reset_op1 got=%h exp=0000", or_R_op1); end
        total++; if (or_R_op2 !== 16'h0) begin bad++; $display("FAIL reset_op2 got=%h exp=0000", or_R_op2); end
        total++; if (or_4_ex_rd !== 4'h0) begin bad++; $display("FAIL reset_ex_rd got=%h exp=0", or_4_ex_rd); end
        total++; if (o_1_reg_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%0h exp=0", o_1_reg_wr_en); end
        tick();
        tick();
        set_wb(1'b0, 4'd0, 16'h0);
        set_dec(1'b0, 4'd0, 4'd0, 4'd0, 16'h0);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_fetch();
        tick();
        i_1_ex_ready = 1'b0;
        set_dec(1'b1, 4'd2, 4'd3, 4'd5, 16'h0104);
        #1;
        total++; if (o_1_dec_ready !== 1'b1) begin bad++; $display("FAIL basic_dec_ready got=%0h exp=1", o_1_dec_ready); end
        total++; if (o_4_rd1_addr !== 4'd2) begin bad++; $display("FAIL basic_rd1_addr got=%h exp=2", o_4_rd1_addr); end
        total++; if (o_4_rd2_addr !== 4'd3) begin bad++; $display("FAIL basic_rd2_addr got=%h exp=3", o_4_rd2_addr); end
        total++; if (o_R_pcplus !== 16'h0104) begin bad++; $display("FAIL basic_pcplus got=%h exp=0104", o_R_pcplus); end
        tick();
        set_dec(1'b0, 4'd0, 4'd0, 4'd0, 16'h0);
        #1;
        total++; if (o_1_dec_ready !== 1'b0) begin bad++; $display("FAIL capture_dec_ready got=%0h exp=0", o_1_dec_ready); end
        total++; if (o_4_rd1_addr !== 4'd2) begin bad++; $display("FAIL capture_rd1_latched got=%h exp=2", o_4_rd1_addr); end
        total++; if (o_R_pcplus !== 16'h0104) begin bad++; $display("FAIL capture_pc_latched got=%h exp=0104", o_R_pcplus); end
        total++; if (o_1_ex_valid !== 1'b0) begin bad++; $display("FAIL capture_ex_valid got=%0h exp=0", o_1_ex_valid); end
        tick();
        total++; if (o_1_ex_valid !== 1'b1) begin bad++; $display("FAIL basic_ex_valid got=%0h exp=1", o_1_ex_valid); end
        total++; if (or_R_op1 !== 16'h0001) begin bad++; $display("FAIL basic_op1 got=%h exp=0001", or_R_op1); end
        total++; if (or_R_op2 !== 16'h0001) begin bad++; $display("FAIL basic_op2 got=%h exp=0001", or_R_op2); end
        total++; if (or_4_ex_rd !== 4'd5) begin bad++; $display("FAIL basic_ex_rd got=%h exp=5", or_4_ex_rd); end
        i_1_ex_ready = 1'b1;
        tick();
        total++; if (o_1_ex_valid !== 1'b0) begin bad++; $display("FAIL basic_ex_valid_clear got=%0h exp=0", o_1_ex_valid); end
    endtask

    task automatic test_wb_then_read();
        tick();
        set_wb(1'b1, 4'd4, 16'h1234);
        #1;
        total++; if (o_1_wb_ready !== 1'b1) begin bad++; $display("FAIL wb_ready got=%0h exp=1", o_1_wb_ready); end
        total++; if (o_1_reg_wr_en !== 1'b1) begin bad++; $display("FAIL wb_wr_en got=%0h exp=1", o_1_reg_wr_en); end
        total++; if (o_4_wr_addr !== 4'd4) begin bad++; $display("FAIL wb_wr_addr got=%h exp=4", o_4_wr_addr); end
        total++; if (o_R_wr_data !== 16'h1234) begin bad++; $display("FAIL wb_wr_data got=%h exp=1234", o_R_wr_data); end
        tick();
        set_wb(1'b0, 4'd0, 16'h0);
        set_dec(1'b1, 4'd4, 4'd15, 4'd1, 16'h0200);
        #1;
        total++; if (o_1_reg_wr_en !== 1'b0) begin bad++; $display("FAIL wb_wr_en_pulse got=%0h exp=0", o_1_reg_wr_en); end
        total++; if (o_1_dec_ready !== 1'b1) begin bad++; $display("FAIL wbread_dec_ready got=%0h exp=1", o_1_dec_ready); end
        tick();
        set_dec(1'b0, 4'd0, 4'd0, 4'd0, 16'h0);
        tick();
        total++; if (o_1_ex_valid !== 1'b1) begin bad++; $display("FAIL wbread_ex_valid got=%0h exp=1", o_1_ex_valid); end
        total++; if (or_R_op1 !== 16'h1234) begin bad++; $display("FAIL wbread_op1 got=%h exp=1234", or_R_op1); end
        total++; if (or_R_op2 !== 16'h0200) begin bad++; $display("FAIL wbread_op2_pc got=%h exp=0200", or_R_op2); end
    endtask

    task automatic test_burst();
        logic [6:0] exp_wb  = 7'b1001111;  // bit k = cycle k
        logic [6:0] exp_dec = 7'b0010000;
        tick();
        i_1_ex_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) tick();
            set_wb(1'b1, 4'd6, 16'h0A00 + 16'(k));
            set_dec(1'b1, 4'd6, 4'd7, 4'd2, 16'h0300);
            #1;
            total++; if (o_1_wb_ready !== exp_wb[k]) begin bad++; $display("FAIL burst_wb_ready[%0d] got=%0h exp=%0h", k, o_1_wb_ready, exp_wb[k]); end
            total++; if (o_1_dec_ready !== exp_dec[k]) begin bad++; $display("FAIL burst_dec_ready[%0d] got=%0h exp=%0h", k, o_1_dec_ready, exp_dec[k]); end
        end
        total++; if (o_1_ex_valid !== 1'b1) begin bad++; $display("FAIL burst_ex_valid got=%0h exp=1", o_1_ex_valid); end
        total++; if (or_R_op1 !== 16'h0A03) begin bad++; $display("FAIL burst_op1 got=%h exp=0a03", or_R_op1); end
        total++; if (or_R_op2 !== 16'h0001) begin bad++; $display("FAIL burst_op2 got=%h exp=0001", or_R_op2); end
        tick();
        set_wb(1'b0, 4'd0, 16'h0);
        set_dec(1'b0, 4'd0, 4'd0, 4'd0, 16'h0);
    endtask

    task automatic test_back_to_back();
        tick();
        i_1_ex_ready = 1'b0;
        set_dec(1'b1, 4'd2, 4'd3, 4'd9, 16'h0400);
        #1;
        total++; if (o_1_dec_ready !== 1'b1) begin bad++; $display("FAIL b2b_first_issue got=%0h exp=1", o_1_dec_ready); end
        tick();
        set_dec(1'b1, 4'd4, 4'd6, 4'd10, 16'h0402);
        #1;
        total++; if (o_1_dec_ready !== 1'b0) begin bad++; $display("FAIL b2b_capture_ready got=%0h exp=0", o_1_dec_ready); end
        for (int c = 0; c < 5; c++) begin
            tick();
            total++; if (o_1_ex_valid !== 1'b1) begin bad++; $display("FAIL stall_ex_valid[%0d] got=%0h exp=1", c, o_1_ex_valid); end
            total++; if (or_R_op1 !== 16'h0001) begin bad++; $display("FAIL stall_op1[%0d] got=%h exp=0001", c, or_R_op1); end
            total++; if (or_R_op2 !== 16'h0001) begin bad++; $display("FAIL stall_op2[%0d] got=%h exp=0001", c, or_R_op2); end
            total++; if (or_4_ex_rd !== 4'd9) begin bad++; $display("FAIL stall_ex_rd[%0d] got=%h exp=9", c, or_4_ex_rd); end
            total++; if (o_1_dec_ready !== 1'b0) begin bad++; $display("FAIL stall_dec_ready[%0d] got=%0h exp=0", c, o_1_dec_ready); end
        end
        tick();
        i_1_ex_ready = 1'b1;
        #1;
        total++; if (o_1_dec_ready !== 1'b1) begin bad++; $display("FAIL b2b_second_issue got=%0h exp=1", o_1_dec_ready); end
        tick();
        set_dec(1'b0, 4'd0, 4'd0, 4'd0, 16'h0);
        total++; if (o_1_ex_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%0h exp=0", o_1_ex_valid); end
        tick();
        total++; if (o_1_ex_valid !== 1'b1) begin bad++; $display("FAIL b2b_second_valid got=%0h exp=1", o_1_ex_valid); end
        total++; if (or_R_op1 !== 16'h1234) begin bad++; $display("FAIL b2b_second_op1 got=%h exp=1234", or_R_op1); end
        total++; if (or_R_op2 !== 16'h0A06) begin bad++; $display("FAIL b2b_second_op2 got=%h exp=0a06", or_R_op2); end
        total++; if (or_4_ex_rd !== 4'd10) begin bad++; $display("FAIL b2b_second_rd got=%h exp=a", or_4_ex_rd); end
    endtask

    task automatic test_wb_r15();
        tick();
        set_wb(1'b1, 4'd15, 16'hFFFF);
        #1;
        total++; if (o_1_wb_ready !== 1'b1) begin bad++; $display("FAIL r15_wb_ready got=%0h exp=1", o_1_wb_ready); end
        total++; if (o_1_reg_wr_en !== 1'b0) begin bad++; $display("FAIL r15_wr_en got=%0h exp=0", o_1_reg_wr_en); end
        tick();
        set_wb(1'b0, 4'd0, 16'h0);
        set_dec(1'b1, 4'd15, 4'd15, 4'd3, 16'h0500);
        tick();
        set_dec(1'b0, 4'd0, 4'd0, 4'd0, 16'h0);
        tick();
        total++; if (or_R_op1 !== 16'h0500) begin bad++; $display("FAIL r15_op1 got=%h exp=0500", or_R_op1); end
        total++; if (or_R_op2 !== 16'h0500) begin bad++; $display("FAIL r15_op2 got=%h exp=0500", or_R_op2); end
    endtask

    task automatic test_reset_mid_capture();
        tick();
        set_dec(1'b1, 4'd2, 4'd3, 4'd7, 16'h0600);
        tick();
        set_dec(1'b0, 4'd8, 4'd9, 4'd0, 16'h0);
        #1;
        total++; if (o_4_rd1_addr !== 4'd2) begin bad++; $display("FAIL midrst_capture_addr got=%h exp=2", o_4_rd1_addr); end
        rst_n = 1'b0;
        #1;
        total++; if (o_1_ex_valid !== 1'b0) begin bad++; $display("FAIL midrst_ex_valid got=%0h exp=0", o_1_ex_valid); end
        total++; if (or_R_op1 !== 16'h0) begin bad++; $display("FAIL midrst_op1 got=%h exp=0000", or_R_op1); end
        total++; if (o_4_rd1_addr !== 4'd8) begin bad++; $display("FAIL midrst_idle_addr got=%h exp=8", o_4_rd1_addr); end
        tick();
        total++; if (o_1_ex_valid !== 1'b0) begin bad++; $display("FAIL midrst_no_capture got=%0h exp=0", o_1_ex_valid); end
        rst_n = 1'b1;
        tick();
        set_dec(1'b1, 4'd4, 4'd15, 4'd11, 16'h0700);
        #1;
        total++; if (o_1_dec_ready !== 1'b1) begin bad++; $display("FAIL postrst_dec_ready got=%0h exp=1", o_1_dec_ready); end
        tick();
        set_dec(1'b0, 4'd0, 4'd0, 4'd0, 16'h0);
        tick();
        total++; if (o_1_ex_valid !== 1'b1) begin bad++; $display("FAIL postrst_ex_valid got=%0h exp=1", o_1_ex_valid); end
        total++; if (or_R_op1 !== 16'h0001) begin bad++; $display("FAIL postrst_op1 got=%h exp=0001", or_R_op1); end
        total++; if (or_R_op2 !== 16'h0700) begin bad++; $display("FAIL postrst_op2 got=%h exp=0700", or_R_op2); end
        total++; if (or_4_ex_rd !== 4'd11) begin bad++; $display("FAIL postrst_ex_rd got=%h exp=b", or_4_ex_rd); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_wb_then_read();
        test_burst();
        test_back_to_back();
        test_wb_r15();
        test_reset_mid_capture();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Register-read stage between instruction decode and the 16-entry register file (r13 SP, r14 LR, r15 = PC+).
- Arbitrates the register file's single-cycle read-or-write access between decoded-instruction operand reads and write-back requests.
- Sequences the 1-cycle registered read and delivers a latched operand pair to execute over a valid/ready handshake.

Parameters:
- REG_WIDTH, 16, data width of the register file, operands and PC value.
- WB_BURST_MAX, 4, maximum consecutive write-back grants while a decode request waits (range 1-15).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_1_dec_valid  in  1  decode presents an instruction.
- o_1_dec_ready  out  1  instruction accepted this cycle.
- i_4_dec_rn  in  4  operand-1 register address.
- i_4_dec_rm  in  4  operand-2 register address.
- i_4_dec_rd  in  4  destination register, forwarded to execute.
- i_R_dec_pc  in  REG_WIDTH  PC+ value for the instruction.
- i_1_wb_valid  in  1  write-back request.
- o_1_wb_ready  out  1  write granted this cycle.
- i_4_wb_addr  in  4  write-back register.
- i_R_wb_data  in  REG_WIDTH  write-back data.
- o_4_rd1_addr  out  4  to register file read port 1.
- o_4_rd2_addr  out  4  to register file read port 2.
- o_4_wr_addr  out  4  to register file write address.
- o_R_wr_data  out  REG_WIDTH  to register file write data.
- o_1_reg_wr_en  out  1  to register file write enable.
- o_R_pcplus  out  REG_WIDTH  to register file PC+ input.
- i_R_rd1_data  in  REG_WIDTH  register file read data 1.
- i_R_rd2_data  in  REG_WIDTH  register file read data 2.
- o_1_ex_valid  out  1  operand pair valid to execute.
- i_1_ex_ready  in  1  execute accepts.
- or_R_op1  out  REG_WIDTH  latched operand 1.
- or_R_op2  out  REG_WIDTH  latched operand 2.
- or_4_ex_rd  out  4  latched destination.

Behaviour:
- Register file contract:
  - When wr_en=0, the register file samples the read addresses at the clock edge; data is valid the following cycle.
  - When wr_en=1, it writes and its read outputs hold.
- Reset (rst_n low, asynchronous):
  - State is IDLE, burst counter is 0.
  - o_1_ex_valid, or_R_op1, or_R_op2 and or_4_ex_rd are 0.
  - o_1_reg_wr_en is 0.
  - Reset mid-read discards the in-flight fetch.
- State IDLE:
  - slot_free = !o_1_ex_valid | i_1_ex_ready.
  - WRITE grant: i_1_wb_valid & !(i_1_dec_valid & slot_free & burst == WB_BURST_MAX).
    - o_1_wb_ready=1, o_1_reg_wr_en=1, wr_addr/wr_data pass through from i_4_wb_addr/i_R_wb_data.
    - burst increments while i_1_dec_valid is high; otherwise burst clears. Stay IDLE.
  - ISSUE: no write grant & i_1_dec_valid & slot_free.
    - o_1_dec_ready=1, o_1_reg_wr_en=0.
    - rd1/rd2 addresses = i_4_dec_rn/rm; o_R_pcplus = i_R_dec_pc.
    - Latch rn, rm, rd and pc; burst clears; go to CAPTURE.
  - Otherwise: rd addresses = dec inputs, o_R_pcplus = i_R_dec_pc, wr_en=0.
- State CAPTURE (exactly 1 cycle):
  - Addresses and o_R_pcplus driven from the latched values; wr_en=0; o_1_dec_ready=0; o_1_wb_ready=0.
  - At the edge: or_R_op1/op2 <= i_R_rd1/rd2_data, or_4_ex_rd <= latched rd, o_1_ex_valid <= 1. Go to IDLE.
- Output register:
  - o_1_ex_valid clears on i_1_ex_ready unless a CAPTURE loads it in the same edge.
  - Contents are stable while valid & !ready.
- Write to address 15: o_1_wb_ready=1 (consumed) but o_1_reg_wr_en is forced 0; the PC is owned by fetch.
- Simultaneous wb and dec requests: write wins until burst reaches WB_BURST_MAX, then one issue is forced.
- Throughput: one instruction per 2 cycles, without writes.

Optional Feature:
- OPF_PERF_CNT_EN defined:
  - Adds output o_16_stall_cnt [15:0], reset 0.
  - Increments each cycle i_1_dec_valid=1 & o_1_dec_ready=0; saturates at 16'hFFFF.
- Not defined: the port and counter are absent.

Test Plan:
- Reset, then dec rn=2, rm=3 (reg file reset values r2=1, r3=1), pc=16'h0104, rd=5 -> dec_ready at cycle 0; ex_valid at cycle 2 with op1=1, op2=1, ex_rd=5.
- wb r4=16'h1234, then dec rn=4, rm=15, pc=16'h0200 -> wr_en pulse of 1 cycle; op1=16'h1234, op2=16'h0200.
- wb_valid held high with dec_valid, WB_BURST_MAX=4 -> 4 write grants, then 1 issue, then writes resume.
- ex_ready low for 5 cycles with back-to-back dec -> op1/op2 stable; second issue waits until the cycle ex_ready rises.
- wb addr 15, data 16'hFFFF -> wb_ready=1, reg_wr_en=0; a subsequent read of r15 returns pc.
- rst_n low during CAPTURE -> ex_valid=0 immediately, state IDLE; the next dec fetch completes normally.
